regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (w_enable / w_addr1 / w_data1) between two writeback sources: s0 = ALU writeback, s1 = load/memory writeback.
- Round-robin arbitration with a valid/ready handshake and a registered write-port output (one-cycle latency).
- Discards writes to register 0.
- Reports the register with a write in flight and counts contention cycles for performance debug.

---
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// the ALU writeback (s0) and the load writeback (s1). Grants are combinational
// valid/ready handshakes; the granted write reaches the port one cycle later.
module regfile_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int CNT_W        = 16,
    parameter bit ZERO_DISCARD = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     hold,
    input  logic                     s0_valid,
    input  logic [ADDR_W-1:0]        s0_addr,
    input  logic [DATA_W-1:0]        s0_data,
    output logic                     s0_ready,
    input  logic                     s1_valid,
    input  logic [ADDR_W-1:0]        s1_addr,
    input  logic [DATA_W-1:0]        s1_data,
    output logic                     s1_ready,
    output logic                     w_enable,
    output logic [ADDR_W-1:0]        w_addr1,
    output logic [DATA_W-1:0]        w_data1,
    output logic [(1<<ADDR_W)-1:0]   busy_mask,
    output logic [CNT_W-1:0]         conflict_cnt
);

    localparam int NREG = 1 << ADDR_W;

    // last_grant_q = 1 means s1 was granted most recently, so s0 wins the next conflict
    logic              last_grant_q, last_grant_d;
    logic              w_en_q, w_en_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [CNT_W-1:0]  conflict_q, conflict_d;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Grant decision: depends only on the valids, hold, reset and the pointer
    always_comb begin
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        if (rst_n && !hold) begin
            s0_ready = s0_valid && (!s1_valid || last_grant_q);
            s1_ready = s1_valid && (!s0_valid || !last_grant_q);
        end
    end

    // Next-state for the write port, pointer and contention counter
    always_comb begin
        sel_addr     = s1_ready ? s1_addr : s0_addr;
        sel_data     = s1_ready ? s1_data : s0_data;
        w_en_d       = 1'b0;
        w_addr_d     = w_addr_q;
        w_data_d     = w_data_q;
        last_grant_d = last_grant_q;
        conflict_d   = conflict_q;
        if (s0_ready || s1_ready) begin
            // register 0 is hardwired: the write is accepted but never enabled
            w_en_d       = !(ZERO_DISCARD && (sel_addr == '0));
            w_addr_d     = sel_addr;
            w_data_d     = sel_data;
            last_grant_d = s1_ready;
        end
        if (s0_valid && s1_valid && !hold && (conflict_q != '1)) begin
            conflict_d = conflict_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            w_en_q       <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            conflict_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            w_en_q       <= w_en_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            conflict_q   <= conflict_d;
        end
    end

    assign w_enable     = w_en_q;
    assign w_addr1      = w_addr_q;
    assign w_data1      = w_data_q;
    assign conflict_cnt = conflict_q;

    // One-hot decode of the register currently being written
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            assign busy_mask[gi] = w_en_q && (w_addr_q == ADDR_W'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a behavioural
// model of the arbitration rules; a second instance uses CNT_W=2 to exercise
// counter saturation.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, hold;
    logic        s0_valid, s1_valid;
    logic [4:0]  s0_addr, s1_addr;
    logic [31:0] s0_data, s1_data;
    logic        s0_ready, s1_ready, w_enable;
    logic [4:0]  w_addr1;
    logic [31:0] w_data1, busy_mask;
    logic [15:0] conflict_cnt;

    logic        sm_s0_ready, sm_s1_ready, sm_w_enable;
    logic [4:0]  sm_w_addr1;
    logic [31:0] sm_w_data1, sm_busy_mask;
    logic [1:0]  sm_conflict_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit          prio_s0;
    bit          exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    int          conflicts;
    bit          g0, g1;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_data(s0_data), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_data(s1_data), .s1_ready(s1_ready),
        .w_enable(w_enable), .w_addr1(w_addr1), .w_data1(w_data1),
        .busy_mask(busy_mask), .conflict_cnt(conflict_cnt)
    );

    regfile_wb_arbiter #(.CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_data(s0_data), .s0_ready(sm_s0_ready),
        .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_data(s1_data), .s1_ready(sm_s1_ready),
        .w_enable(sm_w_enable), .w_addr1(sm_w_addr1), .w_data1(sm_w_data1),
        .busy_mask(sm_busy_mask), .conflict_cnt(sm_conflict_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: inputs are already driven (after a negedge).
    task automatic step();
        bit          r0, r1;
        logic [31:0] exp_busy;
        #1;
        r0 = rst_n && !hold && s0_valid && (!s1_valid || prio_s0);
        r1 = rst_n && !hold && s1_valid && (!s0_valid || !prio_s0);
        check_eq("s0_ready", s0_ready, r0);
        check_eq("s1_ready", s1_ready, r1);
        check_eq("small_s0_ready", sm_s0_ready, r0);
        @(posedge clk);
        g0 = r0;
        g1 = r1;
        if (!rst_n) begin
            exp_we = 0; exp_addr = '0; exp_data = '0; prio_s0 = 1; conflicts = 0;
        end else begin
            if (s0_valid && s1_valid && !hold) conflicts++;
            if (r0 || r1) begin
                exp_addr = r0 ? s0_addr : s1_addr;
                exp_data = r0 ? s0_data : s1_data;
                exp_we   = (exp_addr != 0);
                prio_s0  = r1;
            end else begin
                exp_we = 0;
            end
        end
        exp_busy = exp_we ? (32'd1 << exp_addr) : 32'd0;
        #1;
        check_eq("w_enable", w_enable, exp_we);
        check_eq("w_addr1", w_addr1, exp_addr);
        check_eq("w_data1", w_data1, exp_data);
        check_eq("busy_mask", busy_mask, exp_busy);
        check_eq("conflict_cnt", conflict_cnt, (conflicts > 65535) ? 65535 : conflicts);
        check_eq("small_conflict_cnt", sm_conflict_cnt, (conflicts > 3) ? 3 : conflicts);
        $display("t=%0t rst_n=%0b hold=%0b v=%0b%0b grant=%0b%0b we=%0b addr=%0d data=%08h cnt=%0d",
                 $time, rst_n, hold, s0_valid, s1_valid, g0, g1, w_enable, w_addr1, w_data1, conflict_cnt);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        hold = 0; s0_valid = 0; s1_valid = 0;
        s0_addr = '0; s1_addr = '0; s0_data = '0; s1_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        step();
        step();
        rst_n = 1;
    endtask

    initial begin
        bit p0, p1;
        rst_n = 0;
        idle_inputs();
        @(negedge clk);

        // 1: reset, then a single s0 write
        do_reset();
        check_eq("reset_busy", busy_mask, 32'd0);
        s0_valid = 1; s0_addr = 5; s0_data = 32'hDEADBEEF;
        step();
        check_eq("tp1_busy", busy_mask, 32'h0000_0020);
        check_eq("tp1_data", w_data1, 32'hDEADBEEF);
        s0_valid = 0;
        step();

        // 2: simultaneous requests from reset, s0 first
        do_reset();
        s0_valid = 1; s0_addr = 3; s0_data = 32'h11;
        s1_valid = 1; s1_addr = 4; s1_data = 32'h22;
        step();
        check_eq("tp2_first_addr", w_addr1, 5'd3);
        s0_valid = 0;
        step();
        check_eq("tp2_second_addr", w_addr1, 5'd4);
        check_eq("tp2_conflicts", conflict_cnt, 16'd1);
        s1_valid = 0;
        step();

        // 3: both continuously valid for 6 cycles, alternating grants
        s0_valid = 1; s1_valid = 1;
        for (int i = 0; i < 6; i++) begin
            s0_addr = 5'(i + 1);  s0_data = 32'hA000 + i;
            s1_addr = 5'(i + 10); s1_data = 32'hB000 + i;
            step();
        end
        check_eq("tp3_small_sat", sm_conflict_cnt, 2'd3);
        idle_inputs();
        step();

        // 4: s1 write to register 0 is dropped, then s0 wins the conflict
        s1_valid = 1; s1_addr = 0; s1_data = 32'hFFFFFFFF;
        step();
        check_eq("tp4_we", w_enable, 1'b0);
        s0_valid = 1; s0_addr = 9; s0_data = 32'h99; s1_addr = 12; s1_data = 32'h12;
        step();
        check_eq("tp4_winner", w_addr1, 5'd9);

        // 5: hold with both valid, then resume
        hold = 1;
        for (int i = 0; i < 3; i++) step();
        hold = 0;
        step();
        check_eq("tp5_resume", w_addr1, 5'd12);
        idle_inputs();
        step();

        // 6: grant then immediate reset discards everything
        s0_valid = 1; s0_addr = 7; s0_data = 32'h77;
        step();
        rst_n = 0; s0_valid = 0;
        step();
        check_eq("tp6_addr", w_addr1, 5'd0);
        rst_n = 1;
        step();

        // Randomized traffic with well-behaved requesters
        p0 = 0; p1 = 0;
        for (int i = 0; i < 600; i++) begin
            if (!p0 && ($urandom_range(0, 2) != 0)) begin
                p0 = 1; s0_valid = 1;
                s0_addr = 5'($urandom_range(0, 31)); s0_data = $urandom;
            end
            if (!p1 && ($urandom_range(0, 2) != 0)) begin
                p1 = 1; s1_valid = 1;
                s1_addr = 5'($urandom_range(0, 31)); s1_data = $urandom;
            end
            hold  = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 59) != 0);
            step();
            if (g0) begin p0 = 0; s0_valid = 0; end
            if (g1) begin p1 = 0; s1_valid = 0; end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
